// File: rtl/led_status_driver_if.sv
// LED status driver bus: debug mode code, activity strobe, PWM duty in; board LEDs out.
interface led_status_driver_if;
    logic [1:0] led_dbg;
    logic       act_pulse;
    logic [7:0] pwm_duty;
    logic [7:0] LEDS;

    modport master (output led_dbg, output act_pulse, output pwm_duty, input LEDS);
    modport slave  (input led_dbg, input act_pulse, input pwm_duty, output LEDS);
endinterface

// File: rtl/led_status_driver.sv
// Board LED driver: mode LED (off/on/slow/fast blink), stretched activity LED, heartbeat,
// and an optional PWM brightness LED enabled by the LED_PWM_EN macro.
module led_status_driver #(
    parameter int unsigned TICK_DIV      = 125000,
    parameter int unsigned HB_TICKS      = 500,
    parameter int unsigned SLOW_TICKS    = 250,
    parameter int unsigned FAST_TICKS    = 50,
    parameter int unsigned STRETCH_TICKS = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    led_status_driver_if.slave  bus
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned HB_W   = $clog2(HB_TICKS + 1);
    localparam int unsigned PH_MAX = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned ST_W   = $clog2(STRETCH_TICKS + 1);

    typedef enum logic [1:0] {OFF, ON, BLK_ON, BLK_OFF} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              rate_q, rate_d;
    logic [ST_W-1:0]   stretch_q, stretch_d;
    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic              hb_led_q, hb_led_d;
    logic              tick_c;
    logic [PH_W-1:0]   half_m1_c;
    logic              pwm_led_c;

    assign tick_c    = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign half_m1_c = rate_q ? PH_W'(FAST_TICKS - 1) : PH_W'(SLOW_TICKS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OFF;
            mode_q     <= 2'b00;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            rate_q     <= 1'b0;
            stretch_q  <= '0;
            hb_cnt_q   <= '0;
            hb_led_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= bus.led_dbg;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            rate_q     <= rate_d;
            stretch_q  <= stretch_d;
            hb_cnt_q   <= hb_cnt_d;
            hb_led_q   <= hb_led_d;
        end
    end

    // Tick prescaler, activity stretch (pulse reload beats tick decrement) and heartbeat.
    always_comb begin
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        stretch_d  = stretch_q;
        hb_cnt_d   = hb_cnt_q;
        hb_led_d   = hb_led_q;
        if (bus.act_pulse) begin
            stretch_d = ST_W'(STRETCH_TICKS);
        end else if (tick_c && (stretch_q != '0)) begin
            stretch_d = stretch_q - ST_W'(1);
        end
        if (tick_c) begin
            if (hb_cnt_q == HB_W'(HB_TICKS - 1)) begin
                hb_cnt_d = '0;
                hb_led_d = ~hb_led_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end
        end
    end

    // Mode FSM; rate_q remembers which blink rate is running (0 slow, 1 fast).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rate_d  = rate_q;
        case (state_q)
            BLK_ON, BLK_OFF: begin
                if (!mode_q[1]) begin
                    state_d = mode_q[0] ? ON : OFF;
                    phase_d = '0;
                end else if (mode_q[0] != rate_q) begin
                    rate_d  = mode_q[0];
                    phase_d = '0;
                end else if (tick_c) begin
                    if (phase_q == half_m1_c) begin
                        state_d = (state_q == BLK_ON) ? BLK_OFF : BLK_ON;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            default: begin
                case (mode_q)
                    2'b00:   state_d = OFF;
                    2'b01:   state_d = ON;
                    default: begin
                        state_d = BLK_ON;
                        phase_d = '0;
                        rate_d  = mode_q[0];
                    end
                endcase
            end
        endcase
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt_q;
    logic [7:0] duty_q;

    // Duty shadow reloads only at the period boundary so a duty change never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= 8'd0;
            duty_q    <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                duty_q <= bus.pwm_duty;
            end
        end
    end

    assign pwm_led_c = (pwm_cnt_q < duty_q);
`else
    logic unused_duty;
    assign unused_duty = ^bus.pwm_duty;
    assign pwm_led_c   = 1'b0;
`endif

    assign bus.LEDS = {hb_led_q, pwm_led_c, 4'b0000, (stretch_q != '0),
                       ((state_q == ON) || (state_q == BLK_ON))};

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver with small tick/period parameters.
module tb_led_status_driver;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    led_status_driver_if bus ();

    led_status_driver #(
        .TICK_DIV      (4),
        .HB_TICKS      (3),
        .SLOW_TICKS    (2),
        .FAST_TICKS    (1),
        .STRETCH_TICKS (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int         cycles;
        logic [1:0] dbg;
        logic       act;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs applied right after an edge; act_pulse lasts exactly one cycle.
    task automatic apply_vec(input string name, input vec_t v);
        bus.led_dbg   = v.dbg;
        bus.act_pulse = v.act;
        for (int c = 0; c < v.cycles; c++) begin
            @(posedge clk);
            #1;
            bus.act_pulse = 1'b0;
        end
        check(name, 32'(bus.LEDS), 32'(v.exp));
    endtask

    task automatic count_led6(input int n, output int hi);
        hi = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.LEDS[6]) hi++;
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.led_dbg   = 2'b00;
        bus.act_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("leds_in_reset", 32'(bus.LEDS), 32'h00);
        reset_n = 1'b1;
    endtask

    initial begin
        int hi;
        int exp_a, exp_b;

        // Edge counts E below are rising edges since reset release; tick acts on E%4==0.
        vecs[0]  = '{11, 2'b00, 1'b0, 8'h00};
        vecs[1]  = '{ 1, 2'b00, 1'b0, 8'h80};  // E=12 first heartbeat toggle
        vecs[2]  = '{11, 2'b00, 1'b0, 8'h80};
        vecs[3]  = '{ 1, 2'b00, 1'b0, 8'h00};  // E=24
        vecs[4]  = '{ 1, 2'b01, 1'b0, 8'h00};  // E=25 mode_q updated only
        vecs[5]  = '{ 1, 2'b01, 1'b0, 8'h01};  // E=26 ON
        vecs[6]  = '{ 1, 2'b10, 1'b0, 8'h01};  // E=27 still ON
        vecs[7]  = '{ 8, 2'b10, 1'b0, 8'h01};  // E=35 BLK_ON since 28
        vecs[8]  = '{ 1, 2'b10, 1'b0, 8'h80};  // E=36 BLK_OFF
        vecs[9]  = '{ 7, 2'b10, 1'b0, 8'h80};  // E=43
        vecs[10] = '{ 1, 2'b10, 1'b0, 8'h81};  // E=44 BLK_ON
        vecs[11] = '{ 3, 2'b10, 1'b0, 8'h81};  // E=47
        vecs[12] = '{ 1, 2'b10, 1'b0, 8'h01};  // E=48 phase=1
        vecs[13] = '{ 3, 2'b11, 1'b0, 8'h01};  // E=51 held, phase cleared at 50
        vecs[14] = '{ 1, 2'b11, 1'b0, 8'h00};  // E=52 fast toggle
        vecs[15] = '{ 3, 2'b11, 1'b0, 8'h00};  // E=55
        vecs[16] = '{ 1, 2'b11, 1'b0, 8'h01};  // E=56
        vecs[17] = '{ 4, 2'b11, 1'b0, 8'h80};  // E=60
        vecs[18] = '{ 4, 2'b11, 1'b0, 8'h81};  // E=64
        vecs[19] = '{ 2, 2'b00, 1'b0, 8'h80};  // E=66 OFF
        vecs[20] = '{ 1, 2'b00, 1'b1, 8'h82};  // E=67 stretch=3
        vecs[21] = '{ 4, 2'b00, 1'b0, 8'h82};  // E=71 stretch=2
        vecs[22] = '{ 1, 2'b00, 1'b1, 8'h02};  // E=72 pulse on tick reloads 3
        vecs[23] = '{11, 2'b00, 1'b0, 8'h02};  // E=83 stretch=1
        vecs[24] = '{ 1, 2'b00, 1'b0, 8'h80};  // E=84 stretch expired

        bus.pwm_duty = 8'd0;
        do_reset();
        for (int i = 0; i < 25; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

`ifdef LED_PWM_EN
        exp_a = 64;
        exp_b = 128;
`else
        exp_a = 0;
        exp_b = 0;
`endif
        // Duty shadow stays 0 until pwm_cnt wraps at E=256.
        bus.pwm_duty = 8'd64;
        count_led6(171, hi);
        check("pwm_before_load", 32'(hi), 32'd0);
        count_led6(44, hi);
        bus.pwm_duty = 8'd128;
        begin
            int hi2;
            count_led6(212, hi2);
            check("pwm_period_duty64", 32'(hi + hi2), 32'(exp_a));
        end
        count_led6(256, hi);
        check("pwm_period_duty128", 32'(hi), 32'(exp_b));

        // Mid-blink and mid-stretch, reset must clear LEDs without waiting for an edge.
        bus.led_dbg   = 2'b10;
        bus.act_pulse = 1'b1;
        @(posedge clk);
        #1;
        bus.act_pulse = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_blink_stretch", 32'(bus.LEDS & 8'h03), 32'h03);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(bus.LEDS), 32'h00);
        bus.led_dbg = 2'b00;
        @(posedge clk);
        #1;
        check("leds_held_in_reset", 32'(bus.LEDS), 32'h00);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) apply_vec($sformatf("post_rst%0d", i), vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
